// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder: per-lane TMDS word aligner and symbol decoder.
// Finds bit alignment on control-token runs, then decodes video, control, TERC4 and guard symbols.
module tmds_channel_decoder #(
  parameter int CHANNEL        = 0,
  parameter int CTRL_RUN       = 8,
  parameter int SEARCH_TIMEOUT = 2048,
  parameter int LOSS_TIMEOUT   = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] rx_word,
  output logic       locked,
  output logic [3:0] align_offset,
  output logic       de,
  output logic [1:0] c,
  output logic [7:0] data,
  output logic       terc4_hit,
  output logic [3:0] terc4_data,
  output logic       vguard
);
  localparam int MAX_AB = CTRL_RUN > SEARCH_TIMEOUT ? CTRL_RUN : SEARCH_TIMEOUT;
  localparam int MAXP = MAX_AB > LOSS_TIMEOUT ? MAX_AB : LOSS_TIMEOUT;
  localparam int CW = $clog2(MAXP + 1);
  localparam logic [CW-1:0] RUN_END = CW'(CTRL_RUN);
  localparam logic [CW-1:0] S_END = CW'(SEARCH_TIMEOUT - 1);
  localparam logic [CW-1:0] L_END = CW'(LOSS_TIMEOUT - 1);
  localparam logic [9:0] GUARD = CHANNEL == 1 ? 10'b0100110011 : 10'b1011001100;
  localparam logic [9:0] TERC4 [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};

  typedef enum logic [1:0] {SEARCH, SETTLE, LOCKED} state_t;
  state_t state, state_n;
  logic [9:0] prev, sym;
  logic [19:0] win;
  logic [3:0] offset, offset_n, sym_off, tk, t_nib;
  logic [CW-1:0] timer, timer_n, timer_inc, run_cnt, run_n, run_inc;
  logic [7:0] qm, dec;
  logic [1:0] tok_c;
  logic is_tok, t_hit, lk;

  // Window is chronological: prev holds the older bits in its low half.
  assign win = {rx_word, prev};

  always_ff @(posedge clk) begin
    if (reset) begin
      prev <= '0;
      sym <= '0;
      sym_off <= '0;
    end else begin
      prev <= rx_word;
      sym <= 10'(win >> offset);
      sym_off <= offset;
    end
  end

  assign tk = {sym == 10'b1010101011, sym == 10'b0101010100, sym == 10'b0010101011, sym == 10'b1101010100};
  assign is_tok = |tk;
  assign tok_c = {tk[3] | tk[2], tk[3] | tk[1]};
  assign qm = sym[9] ? ~sym[7:0] : sym[7:0];
  assign dec = {sym[8] ? qm[7:1] ^ qm[6:0] : ~(qm[7:1] ^ qm[6:0]), qm[0]};

  always_comb begin
    t_hit = 1'b0;
    t_nib = '0;
    for (int i = 0; i < 16; i++) begin
      if (sym == TERC4[i]) begin
        t_hit = 1'b1;
        t_nib = 4'(i);
      end
    end
  end

  assign timer_inc = timer == '1 ? timer : timer + 1'b1;
  assign run_inc = run_cnt == '1 ? run_cnt : run_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SEARCH;
      offset <= '0;
      timer <= '0;
      run_cnt <= '0;
    end else begin
      state <= state_n;
      offset <= offset_n;
      timer <= timer_n;
      run_cnt <= run_n;
    end
  end

  always_comb begin
    state_n = state;
    offset_n = offset;
    timer_n = timer_inc;
    run_n = '0;
    case (state)
      SEARCH: begin
        run_n = is_tok ? run_inc : '0;
        if (is_tok && run_inc >= RUN_END) begin
          state_n = LOCKED;
          timer_n = '0;
          run_n = '0;
        end else if (timer == S_END) begin
          state_n = SETTLE;
          offset_n = offset == 4'd9 ? 4'd0 : offset + 4'd1;
        end
      end
      // One dead cycle lets the stage-1 symbol pick up the new offset.
      SETTLE: begin
        state_n = SEARCH;
        timer_n = '0;
      end
      LOCKED: begin
        if (is_tok) timer_n = '0;
        else if (timer == L_END) begin
          state_n = SEARCH;
          timer_n = '0;
        end
      end
      default: state_n = SEARCH;
    endcase
  end

  assign lk = state_n == LOCKED;

  always_ff @(posedge clk) begin
    if (reset) begin
      locked <= 1'b0;
      align_offset <= '0;
      de <= 1'b0;
      c <= '0;
      data <= '0;
      terc4_hit <= 1'b0;
      terc4_data <= '0;
      vguard <= 1'b0;
    end else begin
      locked <= lk;
      align_offset <= sym_off;
      de <= lk && !is_tok;
      c <= !lk ? 2'b00 : is_tok ? tok_c : c;
      data <= dec;
      terc4_hit <= lk && t_hit;
      terc4_data <= t_nib;
      vguard <= lk && sym == GUARD;
    end
  end
endmodule
